// File: rtl/pixel_compositor.sv
// pixel_compositor -- final VGA output stage.
//
// Delays blank/hsync/vsync by SYNC_DLY cycles and overlays NUM_CURSORS
// crosshairs on a pixel chosen from live video, a stored R3:G3:B2 frame or
// black. The source only switches on a vsync_out falling edge, so a frame is
// never split between two sources. Output frames are counted in frame_count.
//
// Ports:
//   clk, reset_n         pixel clock, asynchronous active-low reset
//   video_rgb            live pixel, already SYNC_DLY-1 cycles behind hcount
//   frame_rgb8           stored pixel R3:G3:B2, aligned with video_rgb
//   in_display           stored-frame area flag, aligned with video_rgb
//   hcount, vcount       raster position (undelayed)
//   blank, hsync, vsync  raster controls (blank high, syncs low active)
//   src_sel_req          0 live, 1 stored, 2/3 black
//   cursor_en/x/y/color  packed per-cursor controls, cursor k at [k*W +: W]
//   pixel_out            registered output pixel
//   blank_out/hsync_out/vsync_out  controls delayed SYNC_DLY cycles
//   src_active           source currently applied
//   frame_count          vsync_out falling edges since reset (wraps)
//
// Build option: define PIXEL_COMPOSITOR_CURSOR_INVERT_EN to make cursor hits
// invert the base pixel instead of adding the cursor colour.

module pixel_compositor #(
  parameter int PIX_W       = 24,
  parameter int NUM_CURSORS = 2,
  parameter int SYNC_DLY    = 44,
  parameter int HW          = 11,
  parameter int VW          = 10
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [PIX_W-1:0]             video_rgb,
  input  logic [7:0]                   frame_rgb8,
  input  logic [HW-1:0]                hcount,
  input  logic [VW-1:0]                vcount,
  input  logic                         blank,
  input  logic                         hsync,
  input  logic                         vsync,
  input  logic                         in_display,
  input  logic [1:0]                   src_sel_req,
  input  logic [NUM_CURSORS-1:0]       cursor_en,
  input  logic [NUM_CURSORS*HW-1:0]    cursor_x,
  input  logic [NUM_CURSORS*VW-1:0]    cursor_y,
  input  logic [NUM_CURSORS*PIX_W-1:0] cursor_color,
  output logic [PIX_W-1:0]             pixel_out,
  output logic                         blank_out,
  output logic                         hsync_out,
  output logic                         vsync_out,
  output logic [1:0]                   src_active,
  output logic [15:0]                  frame_count
);

  localparam int CW = PIX_W / 3;     // bits per colour channel
  localparam int HD = SYNC_DLY - 1;  // cursor-hit pipeline depth

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  // ---------------------------------------------------------------------
  // Delay lines. Bit 0 is the newest sample; the MSB drives the outputs.
  // ---------------------------------------------------------------------
  logic [SYNC_DLY-1:0]    blank_dly_q, blank_dly_d;
  logic [SYNC_DLY-1:0]    hsync_dly_q, hsync_dly_d;
  logic [SYNC_DLY-1:0]    vsync_dly_q, vsync_dly_d;
  logic [NUM_CURSORS-1:0] hit_now;
  logic [NUM_CURSORS-1:0] hit_dly_q [HD];
  logic [NUM_CURSORS-1:0] hit_dly_d [HD];

  always_comb begin
    blank_dly_d = {blank_dly_q[SYNC_DLY-2:0], blank};
    hsync_dly_d = {hsync_dly_q[SYNC_DLY-2:0], hsync};
    vsync_dly_d = {vsync_dly_q[SYNC_DLY-2:0], vsync};

    hit_now = '0;
    for (int k = 0; k < NUM_CURSORS; k++) begin
      hit_now[k] = cursor_en[k] &&
                   ((hcount == cursor_x[k*HW +: HW]) ||
                    (vcount == cursor_y[k*VW +: VW]));
    end

    hit_dly_d[0] = hit_now;
    for (int i = 1; i < HD; i++) begin
      hit_dly_d[i] = hit_dly_q[i-1];
    end
  end

  // Hits and blank as seen by the output register: the last hit stage lines
  // up with video_rgb, and the second-to-last blank stage is the value that
  // blank_out takes on the same edge as pixel_out.
  logic [NUM_CURSORS-1:0] hit_al;
  logic                   blank_al;

  assign hit_al   = hit_dly_q[HD-1];
  assign blank_al = blank_dly_q[SYNC_DLY-2];

  // ---------------------------------------------------------------------
  // Pixel datapath
  // ---------------------------------------------------------------------
  // Repeat the short field MSB-first until the channel is full, so 3'b111
  // maps to all-ones and 3'b000 to zero.
  function automatic logic [CW-1:0] rep3(input logic [2:0] v);
    logic [CW-1:0] r;
    r = '0;
    for (int i = 0; i < CW; i++) r[CW-1-i] = v[2-(i%3)];
    return r;
  endfunction

  function automatic logic [CW-1:0] rep2(input logic [1:0] v);
    logic [CW-1:0] r;
    r = '0;
    for (int i = 0; i < CW; i++) r[CW-1-i] = v[1-(i%2)];
    return r;
  endfunction

  logic [1:0]       src_active_q, src_active_d;
  logic [PIX_W-1:0] pixel_q, pixel_d;
  logic [PIX_W-1:0] base;
  logic [PIX_W-1:0] overlay;

  always_comb begin
    case (src_active_q)
      2'd0:    base = video_rgb;
      2'd1:    base = in_display ? {rep3(frame_rgb8[7:5]),
                                    rep3(frame_rgb8[4:2]),
                                    rep2(frame_rgb8[1:0])} : '1;
      default: base = '0;
    endcase
  end

`ifdef PIXEL_COMPOSITOR_CURSOR_INVERT_EN
  // Any number of hits gives one inversion; cursor colours play no part.
  assign overlay = (|hit_al) ? ~base : base;
`else
  // One extra bit catches the carry; clamping after every addition gives the
  // same result as clamping the full sum because the sum only grows.
  always_comb begin
    logic [CW:0] acc;
    overlay = base;
    acc     = '0;
    for (int c = 0; c < 3; c++) begin
      acc = {1'b0, base[c*CW +: CW]};
      for (int k = 0; k < NUM_CURSORS; k++) begin
        if (hit_al[k]) begin
          acc = acc + {1'b0, cursor_color[k*PIX_W + c*CW +: CW]};
          if (acc[CW]) acc = {1'b0, {CW{1'b1}}};
        end
      end
      overlay[c*CW +: CW] = acc[CW-1:0];
    end
  end
`endif

  assign pixel_d = blank_al ? '0 : overlay;

  // ---------------------------------------------------------------------
  // Source-switch FSM and frame counter
  // ---------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [1:0]  pend_src_q, pend_src_d;
  logic        vs_prev_q;
  logic        vs_fall;
  logic [15:0] frame_count_q, frame_count_d;

  // vs_prev_q resets to 1 like the delay line, so release gives no edge.
  assign vs_fall = vs_prev_q & ~vsync_dly_q[SYNC_DLY-1];

  always_comb begin
    state_d       = state_q;
    src_active_d  = src_active_q;
    pend_src_d    = pend_src_q;
    frame_count_d = frame_count_q;

    if (vs_fall) frame_count_d = frame_count_q + 16'd1;

    case (state_q)
      ST_STABLE: begin
        if (src_sel_req != src_active_q) begin
          pend_src_d = src_sel_req;
          state_d    = ST_PENDING;
        end
      end
      ST_PENDING: begin
        // pend_src tracks the request every cycle, so the last value wins.
        pend_src_d = src_sel_req;
        if (src_sel_req == src_active_q) begin
          state_d = ST_STABLE;
        end else if (vs_fall) begin
          src_active_d = pend_src_q;
          state_d      = ST_STABLE;
        end
      end
      default: state_d = ST_STABLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blank_dly_q   <= '1;
      hsync_dly_q   <= '1;
      vsync_dly_q   <= '1;
      for (int i = 0; i < HD; i++) hit_dly_q[i] <= '0;
      pixel_q       <= '0;
      state_q       <= ST_STABLE;
      src_active_q  <= 2'd0;
      pend_src_q    <= 2'd0;
      vs_prev_q     <= 1'b1;
      frame_count_q <= '0;
    end else begin
      blank_dly_q   <= blank_dly_d;
      hsync_dly_q   <= hsync_dly_d;
      vsync_dly_q   <= vsync_dly_d;
      for (int i = 0; i < HD; i++) hit_dly_q[i] <= hit_dly_d[i];
      pixel_q       <= pixel_d;
      state_q       <= state_d;
      src_active_q  <= src_active_d;
      pend_src_q    <= pend_src_d;
      vs_prev_q     <= vsync_dly_q[SYNC_DLY-1];
      frame_count_q <= frame_count_d;
    end
  end

  assign pixel_out   = pixel_q;
  assign blank_out   = blank_dly_q[SYNC_DLY-1];
  assign hsync_out   = hsync_dly_q[SYNC_DLY-1];
  assign vsync_out   = vsync_dly_q[SYNC_DLY-1];
  assign src_active  = src_active_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_pixel_compositor.sv
// Testbench for pixel_compositor: drives a small raster (64x12 timing) with
// randomized and scripted content and compares every output on every cycle
// against a reference model built from per-cycle input history.
module tb_pixel_compositor;

  localparam int PIX_W = 24;
  localparam int NC    = 2;
  localparam int D     = 44;
  localparam int HW    = 11;
  localparam int VW    = 10;
  localparam int HT    = 64;
  localparam int VT    = 12;
  localparam int FR    = HT * VT;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [PIX_W-1:0]    video_rgb;
  logic [7:0]          frame_rgb8;
  logic [HW-1:0]       hcount;
  logic [VW-1:0]       vcount;
  logic                blank, hsync, vsync, in_display;
  logic [1:0]          src_sel_req;
  logic [NC-1:0]       cursor_en;
  logic [NC*HW-1:0]    cursor_x;
  logic [NC*VW-1:0]    cursor_y;
  logic [NC*PIX_W-1:0] cursor_color;
  logic [PIX_W-1:0]    pixel_out;
  logic                blank_out, hsync_out, vsync_out;
  logic [1:0]          src_active;
  logic [15:0]         frame_count;

  pixel_compositor #(.PIX_W(PIX_W), .NUM_CURSORS(NC), .SYNC_DLY(D),
                     .HW(HW), .VW(VW)) dut (
    .clk(clk), .reset_n(reset_n), .video_rgb(video_rgb),
    .frame_rgb8(frame_rgb8), .hcount(hcount), .vcount(vcount),
    .blank(blank), .hsync(hsync), .vsync(vsync), .in_display(in_display),
    .src_sel_req(src_sel_req), .cursor_en(cursor_en), .cursor_x(cursor_x),
    .cursor_y(cursor_y), .cursor_color(cursor_color), .pixel_out(pixel_out),
    .blank_out(blank_out), .hsync_out(hsync_out), .vsync_out(vsync_out),
    .src_active(src_active), .frame_count(frame_count)
  );

  // ---------------- model state ----------------
  typedef struct {
    logic                blank, hs, vs;
    logic [HW-1:0]       hc;
    logic [VW-1:0]       vc;
    logic [NC-1:0]       en;
    logic [NC*HW-1:0]    cx;
    logic [NC*VW-1:0]    cy;
    logic [NC*PIX_W-1:0] col;
    logic [PIX_W-1:0]    video;
    logic [7:0]          fr;
    logic                ind;
    logic [1:0]          req;
  } rec_t;

  rec_t             hist[$];      // one record per driven cycle, newest last
  logic [PIX_W-1:0] exp_q[$];     // expected pixel_out for the next edge
  logic [1:0]       sa;           // model of src_active
  logic [15:0]      fc;           // model of frame_count
  int               n_vec = 0;
  int               n_err = 0;
  int               hc_c, vc_c, frame_ix, phase, p4_start;

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_pixel"},  32'(pixel_out),   32'h0);
    check_eq({tag, "_blank"},  32'(blank_out),   32'h1);
    check_eq({tag, "_hsync"},  32'(hsync_out),   32'h1);
    check_eq({tag, "_vsync"},  32'(vsync_out),   32'h1);
    check_eq({tag, "_src"},    32'(src_active),  32'h0);
    check_eq({tag, "_fcount"}, 32'(frame_count), 32'h0);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] exp3(input logic [2:0] v);
    logic [7:0] w;
    w = {5'b0, v};
    return (w << 5) | (w << 2) | (w >> 1);
  endfunction

  function automatic logic [7:0] exp2(input logic [1:0] v);
    return 8'(v * 8'd85);
  endfunction

  // now: inputs of the cycle before the output edge (video, colours);
  // old: inputs SYNC_DLY cycles before the output edge (position, blank).
  function automatic logic [PIX_W-1:0] ref_pixel(input rec_t now,
                                                 input rec_t old,
                                                 input logic [1:0] src);
    logic [PIX_W-1:0] base;
    int               ch[3];
    bit               any;
    case (src)
      2'd0:    base = now.video;
      2'd1:    base = now.ind ? {exp3(now.fr[7:5]), exp3(now.fr[4:2]),
                                 exp2(now.fr[1:0])} : 24'hFFFFFF;
      default: base = 24'h0;
    endcase
    if (old.blank) return 24'h0;
    any = 0;
    for (int c = 0; c < 3; c++) ch[c] = int'(base[8*c +: 8]);
    for (int k = 0; k < NC; k++) begin
      if (old.en[k] && (old.hc == old.cx[k*HW +: HW] ||
                        old.vc == old.cy[k*VW +: VW])) begin
        any = 1;
        for (int c = 0; c < 3; c++) ch[c] += int'(now.col[k*PIX_W + 8*c +: 8]);
      end
    end
`ifdef PIXEL_COMPOSITOR_CURSOR_INVERT_EN
    return any ? ~base : base;
`else
    if (!any) return base;
    for (int c = 0; c < 3; c++) if (ch[c] > 255) ch[c] = 255;
    return {ch[2][7:0], ch[1][7:0], ch[0][7:0]};
`endif
  endfunction

  task automatic model_reset();
    rec_t idle;
    idle = '{blank: 1'b1, hs: 1'b1, vs: 1'b1, hc: '0, vc: '0, en: '0,
             cx: '0, cy: '0, col: '0, video: '0, fr: '0, ind: 1'b0, req: '0};
    hist.delete();
    exp_q.delete();
    for (int i = 0; i < D + 2; i++) hist.push_back(idle);
    sa = 2'd0;
    fc = 16'd0;
  endtask

  // Advance the model across one clock edge. A falling vsync_out seen on
  // the previous cycle counts a frame and applies the held request.
  task automatic model_edge();
    int s;
    s = hist.size();
    if (hist[s-2-D].vs && !hist[s-1-D].vs) begin
      fc = fc + 16'd1;
      if (hist[s-1].req != sa) sa = hist[s-1].req;
    end
  endtask

  // ---------------- driver ----------------
  task automatic rand_cursors();
    cursor_en    = NC'($urandom_range(0, (1 << NC) - 1));
    cursor_x     = {11'($urandom_range(0, 70)), 11'($urandom_range(0, 70))};
    cursor_y     = {10'($urandom_range(0, 13)), 10'($urandom_range(0, 13))};
    cursor_color = {24'($urandom), 24'($urandom)};
  endtask

  task automatic drive_and_push();
    rec_t r;
    int   h, v, lf;
    h = hc_c;
    v = vc_c;
    blank  = (h >= 48) || (v >= 10);
    hsync  = !(h >= 52 && h < 56);
    vsync  = (v != 11);
    hcount = HW'(h);
    vcount = VW'(v);
    case (phase)
      0: begin
        video_rgb = 24'($urandom); frame_rgb8 = 8'($urandom);
        in_display = 1'($urandom_range(0, 1)); src_sel_req = 2'd0;
        if (h == 0) rand_cursors();
      end
      1: begin
        video_rgb = 24'h808080; cursor_en = 2'b01;
        cursor_x = {11'd2000, 11'd40}; cursor_y = {10'd1000, 10'd1000};
        cursor_color = {24'h000000, 24'hA00000};
      end
      2: begin
        video_rgb = 24'h0; cursor_en = 2'b11;
        cursor_x = {11'd2000, 11'd20}; cursor_y = {10'd5, 10'd1000};
        cursor_color = {24'h000020, (frame_ix[0] ? 24'h000010 : 24'h0000F0)};
      end
      3: begin
        video_rgb = 24'($urandom); frame_rgb8 = 8'b101_010_11;
        in_display = ((h % 16) < 8); cursor_en = '0;
        if (v == 1 && h == 0) src_sel_req = 2'd1;
      end
      4: begin
        video_rgb = 24'($urandom); frame_rgb8 = 8'($urandom);
        in_display = 1'($urandom_range(0, 1));
        if (h == 0) rand_cursors();
        lf = frame_ix - p4_start;
        if (h == 0) begin
          if (lf == 0 && v == 1) src_sel_req = 2'd0;
          if (lf == 1 && v == 2) src_sel_req = 2'd1;
          if (lf == 1 && v == 4) src_sel_req = 2'd2;
          if (lf == 1 && v == 6) src_sel_req = 2'd0;
          if (lf >= 2 && v == 2) src_sel_req = 2'd2;
        end
      end
      default: begin
        video_rgb = 24'($urandom); frame_rgb8 = 8'($urandom);
        in_display = 1'($urandom_range(0, 1));
        if (h == 0) rand_cursors();
        if (h == 0 && v >= 1 && v <= 8 && $urandom_range(0, 2) == 0)
          src_sel_req = 2'($urandom_range(0, 3));
      end
    endcase
    r = '{blank: blank, hs: hsync, vs: vsync, hc: hcount, vc: vcount,
          en: cursor_en, cx: cursor_x, cy: cursor_y, col: cursor_color,
          video: video_rgb, fr: frame_rgb8, ind: in_display, req: src_sel_req};
    hist.push_back(r);
    exp_q.push_back(ref_pixel(hist[hist.size()-1], hist[hist.size()-D], sa));
    if (hist.size() > D + 8) hist.delete(0);
    hc_c++;
    if (hc_c == HT) begin
      hc_c = 0;
      vc_c++;
      if (vc_c == VT) begin
        vc_c = 0;
        frame_ix++;
      end
    end
  endtask

  // One clock: check outputs 1 ns after the edge, then drive the next cycle.
  task automatic cycle_step();
    int s;
    @(posedge clk);
    #1;
    model_edge();
    s = hist.size();
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard: expected queue empty at t=%0t", $time);
    end else begin
      check_eq("pixel_out", 32'(pixel_out), 32'(exp_q.pop_front()));
    end
    check_eq("blank_out",   32'(blank_out),   32'(hist[s-D].blank));
    check_eq("hsync_out",   32'(hsync_out),   32'(hist[s-D].hs));
    check_eq("vsync_out",   32'(vsync_out),   32'(hist[s-D].vs));
    check_eq("src_active",  32'(src_active),  32'(sa));
    check_eq("frame_count", 32'(frame_count), 32'(fc));
    drive_and_push();
  endtask

  task automatic run_cycles(input int n);
    repeat (n) cycle_step();
  endtask

  task automatic mid_reset();
    #3 reset_n = 1'b0;
    #1 check_reset("async_rst");
    repeat (2) @(posedge clk);
    #1 check_reset("held_rst");
    reset_n = 1'b1;
    model_reset();
    drive_and_push();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset_n = 1'b0;
    video_rgb = '0; frame_rgb8 = '0; hcount = '0; vcount = '0;
    blank = 1'b1; hsync = 1'b1; vsync = 1'b1; in_display = 1'b0;
    src_sel_req = 2'd0; cursor_en = '0; cursor_x = '0; cursor_y = '0;
    cursor_color = '0;
    hc_c = 0; vc_c = 11; frame_ix = 0; phase = 0; p4_start = 0;

    // Release inside the vsync line so vsync_out must hold 1 for D cycles.
    repeat (3) @(posedge clk);
    #1 check_reset("por");
    reset_n = 1'b1;
    model_reset();
    drive_and_push();
    run_cycles(HT - 1);

    phase = 0; run_cycles(2 * FR);               // random live video
    phase = 1; run_cycles(FR);                   // single cursor saturation
    phase = 2; run_cycles(2 * FR);               // crossing cursors
    phase = 3; run_cycles(2 * FR);               // stored frame / white fill
    phase = 4; p4_start = frame_ix;
    run_cycles(4 * FR);                          // cancelled and held switch
    phase = 5; run_cycles(3 * FR);               // everything random

    // Counter wrap: pin the count to 0xFFFF mid-frame.
    run_cycles(3 * HT);
    force dut.frame_count_q = 16'hFFFF;
    fc = 16'hFFFF;
    run_cycles(2);
    release dut.frame_count_q;
    run_cycles(FR + 10);

    // Asynchronous reset in the middle of a line.
    run_cycles(20);
    mid_reset();
    run_cycles(FR);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
